cdb_arbiter: RTL and testbench

//  Collects completions from the NUM_FU functional units and broadcasts one destination tag per

---
 rtl/cdb_arbiter_pkg.sv | 32 +++
 rtl/cdb_fifo.sv | 51 +++++
 rtl/cdb_arbiter.sv | 94 +++++++++
 tb/tb_cdb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: destination tag, completion packet
// and the default sizing of the FU completion ports.
package cdb_arbiter_pkg;
  localparam int CDB_NUM_FU     = 5;
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int ROB_IDX_W      = 5;
  localparam int PHYS_REG_W     = 6;

  typedef struct packed {
    logic [PHYS_REG_W-1:0] phys_reg;
    logic                  ready;
    logic                  valid;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  typedef struct packed {
    tag_t                 tag;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_packet_t;

  localparam int PKT_W = $bits(cdb_packet_t);

  // A tag leaving on the bus always announces a produced, valid value.
  function automatic tag_t broadcast_tag(input tag_t t);
    tag_t r;
    r       = t;
    r.ready = 1'b1;
    r.valid = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/cdb_fifo.sv
// One FU completion FIFO holding CDB packets; pointers wrap naturally, flush empties it.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [PKT_W-1:0]         din,
  output logic [PKT_W-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// Collects FU completions into per-FU FIFOs and broadcasts one tag per cycle on the CDB,
// granting non-empty FIFOs round-robin starting at rr_ptr.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = CDB_NUM_FU,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        interrupt,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic [TAG_W-1:0]            cdb,
  output logic                        cdb_en,
  output logic [ROB_IDX_W-1:0]        cdb_rob_idx
);
  localparam int RR_W = $clog2(NUM_FU);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a completion transfers at a posedge where fu_valid[i] && fu_ready[i];
  // while fu_valid[i] && !fu_ready[i] the FU holds fu_tag/fu_rob_idx stable.
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] empty;
  logic [CW-1:0]     count [NUM_FU];
  cdb_packet_t       heads [NUM_FU];
  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   winner;
  logic              win_valid;
  cdb_packet_t       win_pkt;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    tag_t             in_tag;
    logic [PKT_W-1:0] head_bits;

    assign in_tag      = fu_tag[g*TAG_W +: TAG_W];
    assign fu_ready[g] = (count[g] != CW'(FIFO_DEPTH));
    // No-dest completions handshake normally but are never stored.
    assign push[g]     = fu_valid[g] && fu_ready[g] && in_tag.valid && !interrupt;
    assign pop[g]      = win_valid && (winner == RR_W'(g)) && !interrupt;
    assign heads[g]    = cdb_packet_t'(head_bits);

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (interrupt),
      .din   ({in_tag, fu_rob_idx[g*ROB_IDX_W +: ROB_IDX_W]}),
      .head  (head_bits),
      .empty (empty[g]),
      .count (count[g])
    );
  end

  // Scan offsets from farthest to nearest so the candidate closest to rr_ptr wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!empty[idx]) begin
        win_valid = 1'b1;
        winner    = RR_W'(idx);
      end
    end
  end

  assign win_pkt = heads[winner];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb         <= '0;
      cdb_en      <= 1'b0;
      cdb_rob_idx <= '0;
      rr_ptr      <= '0;
    end else if (interrupt) begin
      cdb_en <= 1'b0;
      rr_ptr <= '0;
    end else if (win_valid) begin
      cdb         <= broadcast_tag(win_pkt.tag);
      cdb_rob_idx <= win_pkt.rob_idx;
      cdb_en      <= 1'b1;
      rr_ptr      <= (winner == RR_W'(NUM_FU - 1)) ? '0 : winner + RR_W'(1);
    end else begin
      cdb_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin contention, backpressure,
// no-dest completions, interrupt flush and asynchronous reset.
module tb_cdb_arbiter;
  localparam int NUM_FU = 5;
  localparam int TW     = 8;
  localparam int RW     = 5;

  logic                   clock;
  logic                   reset;
  logic                   interrupt;
  logic [NUM_FU-1:0]      fu_valid;
  logic [NUM_FU*TW-1:0]   fu_tag;
  logic [NUM_FU*RW-1:0]   fu_rob_idx;
  logic [NUM_FU-1:0]      fu_ready;
  logic [TW-1:0]          cdb;
  logic                   cdb_en;
  logic [RW-1:0]          cdb_rob_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  cdb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .interrupt   (interrupt),
    .fu_valid    (fu_valid),
    .fu_tag      (fu_tag),
    .fu_rob_idx  (fu_rob_idx),
    .fu_ready    (fu_ready),
    .cdb         (cdb),
    .cdb_en      (cdb_en),
    .cdb_rob_idx (cdb_rob_idx)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_fu(input int i, input logic v, input logic [5:0] phys,
                          input logic tv, input logic [4:0] rob);
    fu_valid[i]            = v;
    fu_tag[i*TW +: TW]     = {phys, 1'b0, tv};
    fu_rob_idx[i*RW +: RW] = rob;
  endtask

  task automatic idle_inputs();
    interrupt  = 1'b0;
    fu_valid   = '0;
    fu_tag     = '0;
    fu_rob_idx = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] bus_tag(input logic [5:0] phys);
    return {phys, 2'b11};
  endfunction

  initial begin
    int          bcasts;
    int          fu4_seq;
    logic        acc4;
    logic [5:0]  p;

    idle_inputs();
    reset = 1'b0;
    #2;
    check("reset_cdb_en", cdb_en, 0);
    check("reset_cdb", cdb, 0);
    check("reset_rob", cdb_rob_idx, 0);
    reset_dut();
    check("reset_fu_ready", fu_ready, 5'h1f);

    // Single completion: visible two cycles after fu_valid, for one cycle only.
    drive_fu(3, 1'b1, 6'd17, 1'b1, 5'd4);
    check("single_c1_en", cdb_en, 0);
    tick();
    drive_fu(3, 1'b0, 6'd0, 1'b0, 5'd0);
    check("single_c2_en", cdb_en, 0);
    tick();
    check("single_c3_en", cdb_en, 1);
    check("single_c3_cdb", cdb, bus_tag(6'd17));
    check("single_c3_rob", cdb_rob_idx, 4);
    tick();
    check("single_c4_en", cdb_en, 0);

    // Contention from rr_ptr=0, then prove rr_ptr landed on 4.
    reset_dut();
    drive_fu(0, 1'b1, 6'd5, 1'b1, 5'd1);
    drive_fu(1, 1'b1, 6'd6, 1'b1, 5'd2);
    drive_fu(3, 1'b1, 6'd7, 1'b1, 5'd3);
    tick();
    idle_inputs();
    tick();
    check("cont_0_cdb", cdb, bus_tag(6'd5));
    check("cont_0_rob", cdb_rob_idx, 1);
    tick();
    check("cont_1_cdb", cdb, bus_tag(6'd6));
    check("cont_1_en", cdb_en, 1);
    tick();
    check("cont_2_cdb", cdb, bus_tag(6'd7));
    check("cont_2_rob", cdb_rob_idx, 3);
    tick();
    check("cont_idle_en", cdb_en, 0);
    drive_fu(0, 1'b1, 6'd10, 1'b1, 5'd10);
    drive_fu(4, 1'b1, 6'd11, 1'b1, 5'd11);
    tick();
    idle_inputs();
    tick();
    check("rr4_first", cdb, bus_tag(6'd11));
    tick();
    check("rr4_second", cdb, bus_tag(6'd10));

    // Backpressure on FU 4 with FUs 0-3 busy; hand-derived broadcast order.
    reset_dut();
    exp_q   = '{6'd20, 6'd21, 6'd22, 6'd23, 6'd30, 6'd24,
                6'd25, 6'd26, 6'd27, 6'd31, 6'd32, 6'd33};
    fu4_seq = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (c < 2) drive_fu(i, 1'b1, 6'(20 + 4*c + i), 1'b1, 5'(20 + 4*c + i));
        else       drive_fu(i, 1'b0, 6'd0, 1'b0, 5'd0);
      end
      if (fu4_seq < 4) drive_fu(4, 1'b1, 6'(30 + fu4_seq), 1'b1, 5'(30 + fu4_seq));
      else             drive_fu(4, 1'b0, 6'd0, 1'b0, 5'd0);
      if (c == 2) check("bp_ready_full", fu_ready, 5'b00001);
      acc4 = fu_valid[4] && fu_ready[4];
      tick();
      if (acc4) fu4_seq++;
      if (cdb_en) begin
        if (exp_q.size() == 0) check("bp_extra_en", cdb_en, 0);
        else begin
          p = exp_q.pop_front();
          check("bp_cdb", cdb, bus_tag(p));
          check("bp_rob", cdb_rob_idx, 5'(p));
        end
      end
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_fu4_all_sent", fu4_seq, 4);

    // No-destination completion: accepted, never broadcast.
    reset_dut();
    drive_fu(2, 1'b1, 6'd9, 1'b0, 5'd9);
    check("nodest_ready", fu_ready[2], 1);
    tick();
    idle_inputs();
    bcasts = 0;
    repeat (5) begin
      tick();
      if (cdb_en) bcasts++;
    end
    check("nodest_bcasts", bcasts, 0);
    check("nodest_fu_ready", fu_ready, 5'h1f);

    // Interrupt flush with a same-cycle completion.
    reset_dut();
    drive_fu(0, 1'b1, 6'd1, 1'b1, 5'd1);
    drive_fu(1, 1'b1, 6'd2, 1'b1, 5'd2);
    drive_fu(2, 1'b1, 6'd3, 1'b1, 5'd3);
    tick();
    idle_inputs();
    interrupt = 1'b1;
    drive_fu(0, 1'b1, 6'd8, 1'b1, 5'd8);
    tick();
    idle_inputs();
    check("flush_en", cdb_en, 0);
    check("flush_fu_ready", fu_ready, 5'h1f);
    bcasts = 0;
    repeat (5) begin
      tick();
      if (cdb_en) bcasts++;
    end
    check("flush_bcasts", bcasts, 0);

    // Asynchronous reset while a broadcast is on the bus.
    reset_dut();
    drive_fu(1, 1'b1, 6'd12, 1'b1, 5'd12);
    drive_fu(3, 1'b1, 6'd13, 1'b1, 5'd13);
    tick();
    idle_inputs();
    tick();
    check("areset_pre_en", cdb_en, 1);
    #3 reset = 1'b0;
    #1;
    check("areset_en", cdb_en, 0);
    check("areset_cdb", cdb, 0);
    check("areset_fu_ready", fu_ready, 5'h1f);
    #2 reset = 1'b1;
    bcasts = 0;
    repeat (4) begin
      tick();
      if (cdb_en) bcasts++;
    end
    check("areset_bcasts", bcasts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
